// File: rtl/tis_pkg.sv
// Shared constants for the TIS-100 node: read modes, link ids,
// and the read-port arbiter state encoding.
package tis_pkg;

    localparam logic [1:0] RD_FIXED = 2'd0;
    localparam logic [1:0] RD_ANY   = 2'd1;
    localparam logic [1:0] RD_LAST  = 2'd2;
    localparam logic [1:0] RD_NIL   = 2'd3;

    localparam logic [1:0] UP    = 2'd0;
    localparam logic [1:0] RIGHT = 2'd1;
    localparam logic [1:0] DOWN  = 2'd2;
    localparam logic [1:0] LEFT  = 2'd3;

    typedef enum logic {
        IDLE = 1'b0,
        DONE = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick4.sv
// Round-robin picker: first set bit of req scanning ptr, ptr+1, .. mod 4.
// Ports: req[0:3], ptr[0:1] in; found, idx[0:1] out.
module rr_pick4 (
    input  logic [0:3] req,
    input  logic [0:1] ptr,
    output logic       found,
    output logic [0:1] idx
);

    logic [1:0] p;

    // Scan from the farthest offset down so the nearest hit wins.
    always_comb begin
        found = 1'b0;
        idx   = ptr;
        p     = '0;
        for (int k = 3; k >= 0; k--) begin
            p = ptr + 2'(k);
            if (req[p]) begin
                found = 1'b1;
                idx   = p;
            end
        end
    end

endmodule

// File: rtl/any_port_arbiter.sv
// Read-side port arbiter for a TIS-100 node: selects one of four writers
// (FIXED/ANY/LAST/NIL), returns the word, acks the writer, tracks LAST.
// Ports: clk, reset; wr_valid/wr_data0..3/wr_ack writer side;
//        rd_req/rd_mode/rd_port in, rd_valid/rd_data/rd_src/rd_nil out;
//        last_port/last_valid and stall_cnt status.
module any_port_arbiter
    import tis_pkg::*;
#(
    parameter int DW      = 8,
    parameter int STALL_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [0:3]       wr_valid,
    input  logic [0:DW-1]    wr_data0,
    input  logic [0:DW-1]    wr_data1,
    input  logic [0:DW-1]    wr_data2,
    input  logic [0:DW-1]    wr_data3,
    output logic [0:3]       wr_ack,
    input  logic             rd_req,
    input  logic [0:1]       rd_mode,
    input  logic [0:1]       rd_port,
    output logic             rd_valid,
    output logic [0:DW-1]    rd_data,
    output logic [0:1]       rd_src,
    output logic             rd_nil,
    output logic [0:1]       last_port,
    output logic             last_valid,
    output logic [0:STALL_W-1] stall_cnt
);

    arb_state_t state;
    arb_state_t stateNext;

    logic [1:0]         rrPtr;
    logic [1:0]         lastPort;
    logic               lastValid;
    logic [STALL_W-1:0] stallCnt;
    logic [DW-1:0]      rdData;
    logic [1:0]         rdSrc;
    logic               rdNil;
    logic               rdValid;
    logic [0:3]         wrAck;

    logic               pickFound;
    logic [1:0]         pickIdx;

    logic               grant;
    logic               isNil;
    logic               anyGrant;
    logic [1:0]         src;
    logic [0:3]         ackNext;
    logic [DW-1:0]      selData;

    rr_pick4 uPick (
        .req   (wr_valid),
        .ptr   (rrPtr),
        .found (pickFound),
        .idx   (pickIdx)
    );

    always_comb begin
        stateNext = state;
        grant     = 1'b0;
        isNil     = 1'b0;
        src       = '0;
        if (state == DONE) begin
            stateNext = IDLE;
        end else if (rd_req) begin
            unique case (1'b1)
                (rd_mode == RD_FIXED): begin
                    grant = wr_valid[rd_port];
                    src   = rd_port;
                end
                (rd_mode == RD_ANY): begin
                    grant = pickFound;
                    src   = pickIdx;
                end
                (rd_mode == RD_LAST): begin
                    // No ANY grant yet: LAST degrades to NIL.
                    if (lastValid) begin
                        grant = wr_valid[lastPort];
                        src   = lastPort;
                    end else begin
                        grant = 1'b1;
                        isNil = 1'b1;
                    end
                end
                default: begin
                    grant = 1'b1;
                    isNil = 1'b1;
                end
            endcase
            if (grant) begin
                stateNext = DONE;
            end
        end
    end

    assign anyGrant = grant && (rd_mode == RD_ANY);

    always_comb begin
        ackNext = '0;
        if (grant && !isNil) begin
            ackNext[src] = 1'b1;
        end
    end

    always_comb begin
        unique case (src)
            2'd0:    selData = wr_data0;
            2'd1:    selData = wr_data1;
            2'd2:    selData = wr_data2;
            default: selData = wr_data3;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdValid   <= 1'b0;
            wrAck     <= '0;
            rdData    <= '0;
            rdSrc     <= '0;
            rdNil     <= 1'b0;
            rrPtr     <= '0;
            lastPort  <= '0;
            lastValid <= 1'b0;
            stallCnt  <= '0;
        end else begin
            rdValid <= grant;
            wrAck   <= ackNext;
            if (grant) begin
                rdData   <= isNil ? '0 : selData;
                rdSrc    <= isNil ? '0 : src;
                rdNil    <= isNil;
                stallCnt <= '0;
            end else if (state == IDLE && rd_req && stallCnt != '1) begin
                stallCnt <= stallCnt + 1'b1;
            end
            if (anyGrant) begin
                rrPtr     <= src + 2'd1;
                lastPort  <= src;
                lastValid <= 1'b1;
            end
        end
    end

    assign rd_valid   = rdValid;
    assign wr_ack     = wrAck;
    assign rd_data    = rdData;
    assign rd_src     = rdSrc;
    assign rd_nil     = rdNil;
    assign last_port  = lastPort;
    assign last_valid = lastValid;
    assign stall_cnt  = stallCnt;

endmodule
